// File: rtl/rgb_grayscaler_if.sv
// Pixel-side and luma-side handshake bundle for the RGB-to-grayscale converter.
interface rgb_grayscaler_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       pause;
    logic       out_ready;
    logic [7:0] gray_out;
    logic       gray_valid;

    modport master (
        output data_in, data_valid, out_ready,
        input  pause, gray_out, gray_valid
    );

    modport slave (
        input  data_in, data_valid, out_ready,
        output pause, gray_out, gray_valid
    );
endinterface

// File: rtl/rgb_grayscaler.sv
// Streaming RGB-to-luma converter: collects R,G,B bytes, emits one weighted
// luma byte per pixel, and pulses gs_done after the last pixel of an N x M frame.
module rgb_grayscaler #(
    parameter int unsigned N = 5,
    parameter int unsigned M = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic gs_enable,
    output logic gs_done,
    rgb_grayscaler_if.slave bus
);
    localparam int unsigned PIX  = N * M;
    localparam int unsigned CW   = (PIX > 1) ? $clog2(PIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(PIX - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, COMPUTE, OUTPUT, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic [7:0]    gray_q, gray_d;
    logic          pause_q, pause_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [15:0]   acc_c;
    logic          take_c;

    // Weights sum to 256, so the 16-bit sum never overflows; luma is the high byte.
    assign acc_c  = 16'(77) * 16'(r_q) + 16'(150) * 16'(g_q) + 16'(29) * 16'(b_q);
    assign take_c = bus.data_valid && !pause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            gray_q  <= '0;
            pause_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            gray_q  <= gray_d;
            pause_q <= pause_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        gray_d  = gray_q;

        case (state_q)
            IDLE: begin
                phase_d = '0;
                cnt_d   = '0;
                if (gs_enable) state_d = COLLECT;
            end
            COLLECT: begin
                if (take_c) begin
                    case (phase_q)
                        2'd0: begin
                            r_d     = bus.data_in;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            g_d     = bus.data_in;
                            phase_d = 2'd2;
                        end
                        default: begin
                            b_d     = bus.data_in;
                            phase_d = 2'd0;
                            state_d = COMPUTE;
                        end
                    endcase
                end
            end
            COMPUTE: begin
                gray_d  = 8'(acc_c >> 8);
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = COLLECT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Moore outputs are registered from the next state.
        pause_d = (state_d != COLLECT);
        valid_d = (state_d == OUTPUT);
        done_d  = (state_d == DONE);
    end

    assign bus.pause      = pause_q;
    assign bus.gray_out   = gray_q;
    assign bus.gray_valid = valid_q;
    assign gs_done        = done_q;
endmodule

// File: tb/tb_rgb_grayscaler.sv
// Directed bench for rgb_grayscaler: a 1x1 instance for per-pixel checks and a
// 5x5 instance for full-frame and mid-pixel reset scenarios.
module tb_rgb_grayscaler;
    logic clk = 1'b0;
    logic rst;
    logic en1, en5, done1, done5;

    always #5 clk = ~clk;

    rgb_grayscaler_if if1();
    rgb_grayscaler_if if5();

    rgb_grayscaler #(.N(1), .M(1)) u_dut1 (
        .clk(clk), .rst(rst), .gs_enable(en1), .gs_done(done1), .bus(if1.slave)
    );
    rgb_grayscaler #(.N(5), .M(5)) u_dut5 (
        .clk(clk), .rst(rst), .gs_enable(en5), .gs_done(done5), .bus(if5.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int dc1 = 0;
    int dc5 = 0;

    always @(posedge clk) begin
        if (done1) dc1++;
        if (done5) dc5++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pause_of(input bit sel);
        return sel ? if5.pause : if1.pause;
    endfunction
    function automatic logic valid_of(input bit sel);
        return sel ? if5.gray_valid : if1.gray_valid;
    endfunction
    function automatic logic [7:0] gray_of(input bit sel);
        return sel ? if5.gray_out : if1.gray_out;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? done5 : done1;
    endfunction

    task automatic drive(input bit sel, input logic [7:0] d, input logic v);
        if (sel) begin
            if5.data_in = d; if5.data_valid = v;
        end else begin
            if1.data_in = d; if1.data_valid = v;
        end
    endtask

    // Present one byte as soon as pause is low; returns one negedge after acceptance.
    task automatic feed(input bit sel, input logic [7:0] d);
        int t = 0;
        while (pause_of(sel) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("feed_timeout", 1, 0);
        drive(sel, d, 1'b1);
        @(negedge clk);
        drive(sel, 8'h00, 1'b0);
    endtask

    task automatic start(input bit sel);
        int t = 0;
        while (done_of(sel) && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (sel) en5 = 1'b1; else en1 = 1'b1;
        @(negedge clk);
        if (sel) en5 = 1'b0; else en1 = 1'b0;
    endtask

    // Feed one pixel, check COMPUTE/OUTPUT timing and value; out_ready must be 1.
    task automatic run_pixel(input bit sel, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input int exp, input string tag,
                             input int gap);
        feed(sel, r);
        feed(sel, g);
        repeat (gap) @(negedge clk);
        feed(sel, b);
        check({tag, "_pause_compute"}, int'(pause_of(sel)), 1);
        check({tag, "_valid_compute"}, int'(valid_of(sel)), 0);
        @(negedge clk);
        check({tag, "_valid_output"}, int'(valid_of(sel)), 1);
        check({tag, "_gray"}, int'(gray_of(sel)), exp);
        @(negedge clk);
    endtask

    logic [7:0] sr [6] = '{8'd255, 8'd255, 8'd0,   8'd0,   8'd100, 8'd0};
    logic [7:0] sg [6] = '{8'd255, 8'd0,   8'd255, 8'd0,   8'd150, 8'd0};
    logic [7:0] sb [6] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd200, 8'd0};
    int         sx [6] = '{255, 76, 149, 28, 140, 0};

    logic [7:0] pr [25], pg [25], pb [25], got [25];
    int         pexp [25];
    int         ntr, done_at, base;

    function automatic logic [7:0] frame_byte(input int idx);
        case (idx % 3)
            0:       return pr[idx / 3];
            1:       return pg[idx / 3];
            default: return pb[idx / 3];
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en1 = 1'b0; en5 = 1'b0;
        if1.data_in = 8'hFF; if1.data_valid = 1'b1; if1.out_ready = 1'b1;
        if5.data_in = 8'hFF; if5.data_valid = 1'b1; if5.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pause",  int'(if1.pause), 1);
        check("rst_valid",  int'(if1.gray_valid), 0);
        check("rst_done",   int'(done1), 0);
        check("rst_gray",   int'(if1.gray_out), 0);
        check("rst_pause5", int'(if5.pause), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_pause", int'(if1.pause), 1);
        check("idle_valid", int'(if1.gray_valid), 0);
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);

        // Single pixels on the 1x1 instance.
        for (int i = 0; i < 6; i++) begin
            base = dc1;
            start(0);
            run_pixel(0, sr[i], sg[i], sb[i], sx[i], $sformatf("single%0d", i), 0);
            check($sformatf("single%0d_done", i), int'(done1), 1);
            check($sformatf("single%0d_valid_done", i), int'(if1.gray_valid), 0);
            @(negedge clk);
            check($sformatf("single%0d_done_low", i), int'(done1), 0);
            check($sformatf("single%0d_idle_pause", i), int'(if1.pause), 1);
            check($sformatf("single%0d_done_count", i), dc1 - base, 1);
        end

        // Input gap between G and B.
        start(0);
        run_pixel(0, 8'd100, 8'd150, 8'd200, 140, "gap", 3);
        check("gap_done", int'(done1), 1);
        @(negedge clk);

        // Output backpressure with data_valid held high.
        if1.out_ready = 1'b0;
        start(0);
        feed(0, 8'd100);
        feed(0, 8'd150);
        feed(0, 8'd200);
        @(negedge clk);
        drive(0, 8'hAA, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", int'(if1.gray_valid), 1);
            check("bp_gray",  int'(if1.gray_out), 140);
            check("bp_pause", int'(if1.pause), 1);
            @(negedge clk);
        end
        if1.out_ready = 1'b1;
        drive(0, 8'h00, 1'b0);
        @(negedge clk);
        check("bp_done", int'(done1), 1);
        @(negedge clk);
        start(0);
        run_pixel(0, 8'd0, 8'd0, 8'd255, 28, "after_bp", 0);

        // Full 5x5 frame with random valid and ready gaps.
        for (int i = 0; i < 25; i++) begin
            pr[i] = 8'($urandom_range(0, 255));
            pg[i] = 8'($urandom_range(0, 255));
            pb[i] = 8'($urandom_range(0, 255));
            pexp[i] = (77 * int'(pr[i]) + 150 * int'(pg[i]) + 29 * int'(pb[i])) / 256;
        end
        base = dc5;
        ntr = 0;
        done_at = -1;
        start(1);
        fork
            begin : driver
                int idx = 0;
                int t = 0;
                while (idx < 75 && t < 4000) begin
                    if (!if5.pause && $urandom_range(0, 3) != 0) begin
                        drive(1, frame_byte(idx), 1'b1);
                        idx++;
                    end else if (if5.pause) begin
                        drive(1, 8'h5A, 1'($urandom_range(0, 1)));
                    end else begin
                        drive(1, 8'h5A, 1'b0);
                    end
                    @(negedge clk);
                    t++;
                end
                drive(1, 8'h00, 1'b0);
            end
            begin : consumer
                int   t = 0;
                logic pv, prd;
                logic [7:0] pgr;
                pv  = if5.gray_valid;
                pgr = if5.gray_out;
                prd = ($urandom_range(0, 2) != 0);
                if5.out_ready = prd;
                while (t < 4000 && done_at < 0) begin
                    @(negedge clk);
                    t++;
                    if (pv && prd) begin
                        if (ntr < 25) got[ntr] = pgr;
                        ntr++;
                    end
                    if (done5) done_at = ntr;
                    pv  = if5.gray_valid;
                    pgr = if5.gray_out;
                    prd = ($urandom_range(0, 2) != 0);
                    if5.out_ready = prd;
                end
            end
        join
        if5.out_ready = 1'b1;
        @(negedge clk);
        check("frame_transfers", ntr, 25);
        check("frame_done_at", done_at, 25);
        check("frame_done_count", dc5 - base, 1);
        for (int i = 0; i < 25 && i < ntr; i++)
            check($sformatf("frame_px%0d", i), int'(got[i]), pexp[i]);

        // Reset in the middle of a pixel, partway through a frame.
        start(1);
        run_pixel(1, 8'd10, 8'd20, 8'd30, 18, "pre0", 0);
        run_pixel(1, 8'd200, 8'd100, 8'd50, 124, "pre1", 0);
        feed(1, 8'd255);
        feed(1, 8'd255);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_pause", int'(if5.pause), 1);
        check("midrst_valid", int'(if5.gray_valid), 0);
        base = dc5;
        start(1);
        run_pixel(1, 8'd0, 8'd0, 8'd255, 28, "post0", 0);
        for (int i = 1; i < 25; i++) begin
            check($sformatf("post%0d_no_done", i), int'(done5), 0);
            run_pixel(1, 8'd0, 8'd0, 8'd255, 28, $sformatf("post%0d", i), 0);
        end
        check("post_done", int'(done5), 1);
        @(negedge clk);
        check("post_done_count", dc5 - base, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
